// File: rtl/arithmetic.sv
// Registered 16-function ALU stage: a combinational result/flag selected by
// `sel`, captured into `out`/`carryout` on every rising clock edge.
module arithmetic #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             carryout
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic               div_zero;
  logic [WIDTH-1:0]   res;
  logic               flag;

  // Shared wide datapath terms; the extra MSB of sum/diff is the carry/borrow.
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  assign prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign div_zero = (b == '0);
  // Divide by zero is pinned to all-ones rather than left to the divider.
  assign quot     = div_zero ? '1 : (a / b);

  // Function select: result and flag, flag defaults to 0 for logic/compare ops.
  always_comb begin
    res  = '0;
    flag = 1'b0;
    unique case (sel)
      OP_ADD:  begin res = sum[WIDTH-1:0];  flag = sum[WIDTH];  end
      OP_SUB:  begin res = diff[WIDTH-1:0]; flag = diff[WIDTH]; end
      OP_MUL:  begin
        res  = prod[WIDTH-1:0];
        flag = (prod[2*WIDTH-1:WIDTH] != '0);
      end
      OP_DIV:  begin res = quot; flag = div_zero; end
      OP_SHL:  begin res = {a[WIDTH-2:0], 1'b0}; flag = a[WIDTH-1]; end
      OP_SHR:  begin res = {1'b0, a[WIDTH-1:1]}; flag = a[0]; end
      OP_ROL:  res = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  res = {a[0], a[WIDTH-1:1]};
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_NAND: res = ~(a & b);
      OP_XNOR: res = ~(a ^ b);
      OP_GT:   res = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_EQ:   res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: begin res = '0; flag = 1'b0; end
    endcase
  end

  // Output register; reset clears any pending result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out      <= '0;
      carryout <= 1'b0;
    end else begin
      out      <= res;
      carryout <= flag;
    end
  end

endmodule

// File: tb/tb_arithmetic.sv
// Bench for the registered ALU: a behavioural model checked every cycle,
// directed literal cases, then randomized operands and selects.
module tb_arithmetic;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] sel;
  logic [7:0] out;
  logic       carryout;

  int errors = 0;
  int checks = 0;

  arithmetic #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel),
    .out(out), .carryout(carryout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: result and flag from plain integer arithmetic, returned {c, r}.
  function automatic logic [8:0] model(input int ai, input int bi, input int s);
    int r;
    int c;
    r = 0;
    c = 0;
    case (s)
      0:  begin r = (ai + bi) % 256; c = (ai + bi > 255) ? 1 : 0; end
      1:  begin r = (ai - bi + 256) % 256; c = (ai < bi) ? 1 : 0; end
      2:  begin r = (ai * bi) % 256; c = (ai * bi > 255) ? 1 : 0; end
      3:  begin
        if (bi == 0) begin r = 255; c = 1; end
        else r = ai / bi;
      end
      4:  begin r = (ai * 2) % 256; c = (ai >= 128) ? 1 : 0; end
      5:  begin r = ai / 2; c = ai % 2; end
      6:  r = (ai * 2) % 256 + ai / 128;
      7:  r = ai / 2 + (ai % 2) * 128;
      8:  r = ai & bi;
      9:  r = ai | bi;
      10: r = ai ^ bi;
      11: r = 255 - (ai | bi);
      12: r = 255 - (ai & bi);
      13: r = 255 - (ai ^ bi);
      14: r = (ai > bi) ? 1 : 0;
      default: r = (ai == bi) ? 1 : 0;
    endcase
    return {c[0], r[7:0]};
  endfunction

  task automatic chk(input string name, input logic [7:0] got_r, input logic got_c,
                     input logic [7:0] exp_r, input logic exp_c);
    checks++;
    if (got_r !== exp_r || got_c !== exp_c) begin
      errors++;
      $display("FAIL %s: got out=%02h c=%b, want out=%02h c=%b",
               name, got_r, got_c, exp_r, exp_c);
    end
  endtask

  // Per-cycle compare: model of the inputs sampled at this edge vs registered outputs.
  always begin
    logic [8:0] e;
    @(posedge clk);
    if (rst) begin
      #1;
      chk("cycle_reset", out, carryout, 8'h00, 1'b0);
    end else begin
      e = model(int'(a), int'(b), int'(sel));
      #1;
      chk($sformatf("cycle a=%02h b=%02h sel=%0h", a, b, sel), out, carryout, e[7:0], e[8]);
    end
  end

  // One operation: drive on negedge, check the literal result after the next edge.
  task automatic step(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] sv,
                      input logic [7:0] er, input logic ec, input string name);
    @(negedge clk);
    a = av; b = bv; sel = sv;
    @(posedge clk);
    #1;
    chk(name, out, carryout, er, ec);
  endtask

  logic [7:0] sweep_r [16];
  logic       sweep_c [16];

  initial begin
    sweep_r = '{8'hFF, 8'h6E, 8'h00, 8'h14, 8'h05, 8'h14, 8'h05,
                8'h0A, 8'h0B, 8'h01, 8'hF4, 8'hF5, 8'hFE, 8'h00, 8'h00, 8'h15};
    sweep_c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; a = 8'h0A; b = 8'h0B; sel = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", out, carryout, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Put a nonzero value on the outputs, then assert reset mid-cycle.
    step(8'h0A, 8'h0B, 4'h1, 8'hFF, 1'b1, "pre_reset_sub");
    @(negedge clk);
    a = 8'h0A; b = 8'h0B; sel = 4'h0;
    #2 rst = 1'b1;
    #1 chk("async_reset", out, carryout, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("first_after_reset", out, carryout, 8'h15, 1'b0);

    // Sweep sel 1..15 then 0 with fixed operands, back to back.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] s;
      s = 4'(i + 1);
      step(8'h0A, 8'h0B, s, sweep_r[i], sweep_c[i], $sformatf("sweep_sel%0h", s));
    end

    // Overflow and wrap cases.
    step(8'hF6, 8'h0A, 4'h0, 8'h00, 1'b1, "ovf_add");
    step(8'hF6, 8'h0A, 4'h1, 8'hEC, 1'b0, "ovf_sub");
    step(8'hF6, 8'h0A, 4'h2, 8'h9C, 1'b1, "ovf_mul");
    step(8'hF6, 8'h0A, 4'h6, 8'hED, 1'b0, "ovf_rol");
    step(8'hF6, 8'h0A, 4'h7, 8'h7B, 1'b0, "ovf_ror");
    step(8'hF6, 8'h0A, 4'h4, 8'hEC, 1'b1, "ovf_shl");
    step(8'hF6, 8'h0A, 4'hE, 8'h01, 1'b0, "ovf_gt");
    step(8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, "add_wrap");
    step(8'h00, 8'h01, 4'h1, 8'hFF, 1'b1, "sub_wrap");

    // Divide by zero and recovery.
    step(8'h20, 8'h00, 4'h3, 8'hFF, 1'b1, "div_zero");
    step(8'h20, 8'h03, 4'h3, 8'h0A, 1'b0, "div_3");

    // Equality and shift edges.
    step(8'h5A, 8'h5A, 4'hF, 8'h01, 1'b0, "eq_true");
    step(8'h5A, 8'h5A, 4'hE, 8'h00, 1'b0, "gt_equal");
    step(8'h81, 8'h5A, 4'h5, 8'h40, 1'b1, "shr_lsb");
    step(8'h81, 8'h00, 4'h7, 8'hC0, 1'b0, "ror_lsb");

    // Randomized back-to-back operations; the per-cycle compare checks each one.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: a = 8'($urandom_range(0, 1) ? 8'hFF : 8'h00);
        default: a = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: b = 8'($urandom_range(0, 2));
        1: b = a;
        default: b = 8'($urandom);
      endcase
      sel = 4'($urandom);
    end

    // Random mid-cycle reset pulses interleaved with traffic.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom);
      #2 rst = 1'b1;
      #1 chk("rand_async_reset", out, carryout, 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom);
      end
    end

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
